seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment driver: latches a NUM_DIGITS-wide hex value and
//  time-multiplexes it onto a shared segment bus with per-digit anode enables.
//  Adds a ghost-suppression gap between digits, tear-free frame-boundary updates,
//  leading-zero suppression, per-digit blanking and decimal points.
//  Sits between ALU result registers and the board display pins.
// PARAMETERS
//  NUM_DIGITS   4      number of digits scanned (>=1)
//  SCAN_DIV     50000  clk cycles each digit is lit (>=1)
//  GAP_CYCLES   500    clk cycles all anodes off between digits (0 = no gap)
//  SEG_ACT_LOW  1      1: segs/dp active-low; 0: active-high
//  AN_ACT_LOW   1      1: an active-low; 0: active-high
// PORTS
//  clk          in   1             system clock, rising edge
//  reset        in   1             synchronous, active-high reset
//  load         in   1             1-cycle strobe: capture value/blank_mask/dp_in
//  value        in   4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
//  blank_mask   in   NUM_DIGITS    1 = force digit i dark
//  dp_in        in   NUM_DIGITS    1 = light decimal point of digit i
//  lz_suppress  in   1             1 = blank leading zero digits (sampled live)
//  segs         out  7             segments {g,f,e,d,c,b,a}, segs[0]=a
//  dp           out  1             decimal point of active digit
//  an           out  NUM_DIGITS    one-hot digit enable
//  frame_start  out  1             1-cycle pulse when digit 0 turns on
// BEHAVIOUR
//  - Decode (active-low form, 0..F): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
//    Active-high form = bitwise inverse. "Off" = all segments/dp/anodes inactive.
//  - States: ON (an[idx] active for SCAN_DIV cycles), GAP (all off for GAP_CYCLES cycles).
//    ON->GAP after SCAN_DIV cycles (ON->ON with idx+1 when GAP_CYCLES=0); GAP->ON with idx+1.
//    idx wraps NUM_DIGITS-1 -> 0. Frame = NUM_DIGITS*(SCAN_DIV+GAP_CYCLES) cycles.
//  - All outputs are registers updated on the same edge as the state change: an[i] is
//    active exactly SCAN_DIV consecutive cycles per frame; an never has two bits active.
//  - Reset: state=GAP, idx=NUM_DIGITS-1, counter=0, shadow and display regs = 0,
//    segs/dp/an off, frame_start=0. First ON is digit 0, GAP_CYCLES cycles after
//    reset release (next cycle if GAP_CYCLES=0), with frame_start pulsed.
//  - Reset mid-frame: outputs off on the next edge, full restart as above.
//  - load captures inputs into a shadow register; last load before a boundary wins.
//    Shadow copies to display regs on the edge entering ON for digit 0 (frame boundary).
//    A load in the boundary cycle itself is bypassed into that frame.
//  - Digit i is dark (segs off, dp still driven by dp_in[i]) when blank_mask[i]=1, or
//    lz_suppress=1 and digits i..NUM_DIGITS-1 are all 0 and i!=0. Digit 0 never LZ-blanked.
//  - frame_start: high exactly one cycle, coincident with an[0] turning on.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, GAP_CYCLES=1, active-low)
//  - Reset held 3 cycles, release -> outputs off 1 cycle, then an=1110, segs=40, frame_start=1;
//    an cycles 1110,1101,1011,0111 each 4 cycles separated by 1 cycle of an=1111; frame=20.
//  - load value=16'h12AF mid-frame -> current frame shows 0000; next frame digits 0..3 show
//    0E,08,24,79.
//  - load 16'h0000 then 16'h0042 before boundary, lz_suppress=1 -> digits 0,1 = 24,19;
//    digits 2,3 segs=7F, anodes still scanned.
//  - load value=16'h0007, blank_mask=4'b0001, dp_in=4'b0100 -> digit 0 segs=7F; digit 2
//    dp=0; other dp=1.
//  - Assert reset while an=1011 -> next edge an=1111, segs=7F, then restart sequence above.
//  - GAP_CYCLES=0, NUM_DIGITS=1: an stays 0, frame_start pulses every 4 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex display driver for common-anode/cathode
// 7-segment banks. A shadow register collects loads at any time. Its contents
// reach the display registers only at the start of a frame, so a frame never
// shows a mix of two values. A short all-dark gap between digits hides ghosting
// from slow anode drivers.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Output codes for "everything dark", which depend on pin polarity.
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW}};

  typedef enum logic {
    ST_ON,
    ST_GAP
  } state_t;

  // The value, blanking and decimal points for one frame, kept together.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

  // Glyph table in active-low form, with bit 0 = segment a.
  function automatic logic [6:0] glyph_low(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  frame_t            shadow_q, shadow_d;
  frame_t            disp_q, disp_d;
  logic [6:0]        segs_q, segs_d;
  logic              dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic              frame_start_q, frame_start_d;

  logic              enter_on;
  logic              frame_edge;
  logic [3:0]        digit_sel;
  logic              dark_sel;
  logic              dp_sel;
  logic              zero_run;
  logic [NUM_DIGITS-1:0] an_on;

  // Work out the scan sequence, frame-boundary capture and the output values for the next cycle.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    enter_on  = 1'b0;
    idx_next  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d  = ST_ON;
          idx_d    = idx_next;
          cnt_d    = '0;
          enter_on = 1'b1;
        end
      end
      default: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            idx_d    = idx_next;
            enter_on = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
    endcase

    frame_edge = enter_on && (idx_d == '0);

    // A load in the same cycle as the boundary goes straight into that frame.
    shadow_d = shadow_q;
    if (load) begin
      shadow_d.value = value;
      shadow_d.blank = blank_mask;
      shadow_d.dp    = dp_in;
    end
    disp_d = frame_edge ? shadow_d : disp_q;

    // Walk from the most significant digit down, tracking whether everything above is zero.
    digit_sel = 4'h0;
    dark_sel  = 1'b0;
    dp_sel    = 1'b0;
    zero_run  = 1'b1;
    an_on     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_d.value[4*i +: 4] == 4'h0);
      an_on[i] = (state_d == ST_ON) && (idx_d == IDX_W'(i));
      if (idx_d == IDX_W'(i)) begin
        digit_sel = disp_d.value[4*i +: 4];
        dark_sel  = disp_d.blank[i] | (lz_suppress & zero_run & (i != 0));
        dp_sel    = disp_d.dp[i];
      end
    end

    segs_d        = SEG_OFF;
    if ((state_d == ST_ON) && !dark_sel) segs_d = glyph_low(digit_sel) ^ ~SEG_OFF;
    dp_d          = ((state_d == ST_ON) & dp_sel) ^ SEG_ACT_LOW;
    an_d          = an_on ^ AN_OFF;
    frame_start_d = frame_edge;
  end

  // Scan state, frame registers and all pin drivers update together on each clock edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the pre-edge values, whatever the statement order.
    if (reset) begin
      state_q       <= ST_GAP;
      idx_q         <= IDX_LAST;
      cnt_q         <= '0;
      // NOTE: both frame registers are cleared so that the first frame after reset shows a known zero value.
      shadow_q      <= '0;
      disp_q        <= '0;
      segs_q        <= SEG_OFF;
      dp_q          <= SEG_ACT_LOW;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      segs_q        <= segs_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segs        = segs_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. A frame-arithmetic model predicts every output
// cycle by cycle, and directed stimulus pins known glyphs, gaps and the reset behaviour.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int G     = 1;
  localparam int GF    = (G > 0) ? G : 1;
  localparam int P     = S + G;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic        lz_suppress;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  logic [6:0]  segs1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame_start1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .GAP_CYCLES(G), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_mask(blank_mask),
    .dp_in(dp_in), .lz_suppress(lz_suppress), .segs(segs), .dp(dp), .an(an),
    .frame_start(frame_start)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(1), .SCAN_DIV(4), .GAP_CYCLES(0), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .load(load), .value(value[3:0]), .blank_mask(blank_mask[0:0]),
    .dp_in(dp_in[0:0]), .lz_suppress(lz_suppress), .segs(segs1), .dp(dp1), .an(an1),
    .frame_start(frame_start1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge count since reset -> position in frame -> expected pins.
  logic [6:0]  lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          j;
  bit          valid = 1'b0;
  logic [15:0] sh_val, dv_val;
  logic [3:0]  sh_bl, dv_bl, sh_dp, dv_dp;
  logic [6:0]  exp_segs;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fs;
  logic        exp_an1;
  logic        exp_fs1;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      j = 0; valid = 1'b1;
      sh_val = '0; sh_bl = '0; sh_dp = '0;
      dv_val = '0; dv_bl = '0; dv_dp = '0;
    end else if (valid) begin
      j++;
      if (j >= GF && (j - GF) % FRAME == 0) begin
        dv_val = load ? value      : sh_val;
        dv_bl  = load ? blank_mask : sh_bl;
        dv_dp  = load ? dp_in      : sh_dp;
      end
      if (load) begin
        sh_val = value; sh_bl = blank_mask; sh_dp = dp_in;
      end
    end
    exp_segs = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
    if (j >= GF && ((j - GF) % P) < S) begin
      int d;
      logic dark;
      d = ((j - GF) % FRAME) / P;
      dark = dv_bl[d] || (lz_suppress && d != 0 && (dv_val >> (4 * d)) == 16'h0);
      exp_segs = dark ? 7'h7F : lut[(dv_val >> (4 * d)) & 16'hF];
      exp_dp   = ~dv_dp[d];
      exp_an   = ~(4'b0001 << d);
      exp_fs   = ((j - GF) % FRAME) == 0;
    end
    exp_an1 = (j >= 1) ? 1'b0 : 1'b1;
    exp_fs1 = (j >= 1) && ((j - 1) % 4 == 0);
  end

  // Every cycle after the first reset edge, compare all pins against the model.
  initial forever begin
    @(negedge clk);
    if (valid) begin
      check("model_segs", segs, exp_segs);
      check("model_dp", dp, exp_dp);
      check("model_an", an, exp_an);
      check("model_fs", frame_start, exp_fs);
      check("model1_an", an1, exp_an1);
      check("model1_fs", frame_start1, exp_fs1);
    end
  end

  task automatic wait_fs();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 60);
    check("fs_timeout", frame_start, 1);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== target && n < 60);
    check("an_timeout", an, target);
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; value = '0; blank_mask = '0; dp_in = '0; lz_suppress = 1'b0;

    // Reset held for three edges, then release; one dark cycle, then digit 0.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rel_an_off", an, 4'hF);
    check("rel_segs_off", segs, 7'h7F);
    @(negedge clk);
    check("first_an", an, 4'hE);
    check("first_segs", segs, 7'h40);
    check("first_fs", frame_start, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 40);
    check("frame_len", n, 20);
    repeat (4) @(negedge clk);
    check("gap_an", an, 4'hF);
    @(negedge clk);
    check("digit1_an", an, 4'hD);

    // Mid-frame load: the current frame keeps zeros, the next one shows 12AF.
    value = 16'h12AF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("old_frame_an", an, 4'hB);
    check("old_frame_segs", segs, 7'h40);
    wait_fs();
    check("d0_F", segs, 7'h0E);
    repeat (5) @(negedge clk);
    check("d1_an", an, 4'hD);
    check("d1_A", segs, 7'h08);
    repeat (5) @(negedge clk);
    check("d2_2", segs, 7'h24);
    repeat (5) @(negedge clk);
    check("d3_an", an, 4'h7);
    check("d3_1", segs, 7'h79);

    // Two loads before one boundary (the last wins), with leading zeros suppressed.
    value = 16'h0000; load = 1'b1;
    @(negedge clk);
    value = 16'h0042; lz_suppress = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs();
    check("lz_d0", segs, 7'h24);
    repeat (5) @(negedge clk);
    check("lz_d1", segs, 7'h19);
    repeat (5) @(negedge clk);
    check("lz_d2_an", an, 4'hB);
    check("lz_d2_dark", segs, 7'h7F);
    repeat (5) @(negedge clk);
    check("lz_d3_an", an, 4'h7);
    check("lz_d3_dark", segs, 7'h7F);

    // Blank mask and decimal points.
    value = 16'h0007; blank_mask = 4'b0001; dp_in = 4'b0100; lz_suppress = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs();
    check("blank_d0_segs", segs, 7'h7F);
    check("blank_d0_dp", dp, 1);
    repeat (5) @(negedge clk);
    check("d1_dp", dp, 1);
    repeat (5) @(negedge clk);
    check("d2_dp_on", dp, 0);
    check("d2_segs", segs, 7'h40);
    repeat (5) @(negedge clk);
    check("d3_dp", dp, 1);

    // A load in the boundary cycle goes straight into the new frame.
    repeat (4) @(negedge clk);
    check("pre_bnd_gap", an, 4'hF);
    value = 16'h3C05; blank_mask = 4'b0000; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("bypass_fs", frame_start, 1);
    check("bypass_segs", segs, 7'h12);

    // Reset while digit 2 is lit: dark on the next edge, then a full restart from zeros.
    wait_an(4'hB);
    reset = 1'b1;
    @(negedge clk);
    check("rst_an_off", an, 4'hF);
    check("rst_segs_off", segs, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    check("restart_an", an, 4'hE);
    check("restart_fs", frame_start, 1);
    check("restart_segs", segs, 7'h40);
    repeat (45) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
